// File: rtl/ctrl_mem_read.sv
// Block read controller: streams rd_len words from a synchronous-read memory
// onto a valid/ready master port through a 2-entry output buffer.
module ctrl_mem_read #(
  parameter int MEM_ADDR_WIDTH = 3,
  parameter int MEM_SIZE       = 8,
  parameter int DATA_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] start_addr,
  input  logic [MEM_ADDR_WIDTH:0]   rd_len,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_rd_en,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  localparam logic [MEM_ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_TOP = MEM_ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                    r_state, w_state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [MEM_ADDR_WIDTH:0]   r_len, r_issued, r_sent;
  logic                      r_inflight;
  logic [DATA_WIDTH-1:0]     r_head, r_skid;
  logic                      r_head_v, r_skid_v;

  logic       w_pop, w_push, w_last_word, w_rd_en;
  logic [1:0] w_occ, w_used;

  assign w_pop       = r_head_v & m_ready;
  assign w_push      = r_inflight;
  assign w_last_word = (r_sent == r_len - LEN_ONE);
  assign w_occ       = {1'b0, r_head_v} + {1'b0, r_skid_v};
  // Credit counts the slot freed by this cycle's pop so back-to-back reads
  // keep flowing at one word per cycle; buffer still never exceeds 2 words.
  assign w_used      = w_occ + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_rd_en     = (r_state == S_STREAM) && (r_issued < r_len) && (w_used < 2'd2);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_rd_en   = w_rd_en;
    mem_addr    = r_addr;
    m_valid     = r_head_v;
    m_data      = r_head;
    m_last      = r_head_v && w_last_word;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = (rd_len != '0) ? S_STREAM : S_DONE;
      S_STREAM: if (w_pop && w_last_word) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (r_state == S_IDLE && start) begin
        r_addr   <= start_addr;
        r_len    <= rd_len;
        r_issued <= '0;
        r_sent   <= '0;
      end else begin
        if (w_rd_en) begin
          r_addr   <= (r_addr == ADDR_TOP) ? '0 : r_addr + 1'b1;
          r_issued <= r_issued + LEN_ONE;
        end
        if (w_pop) r_sent <= r_sent + LEN_ONE;
      end
    end
  end

  // Head feeds the port; skid only fills when head is occupied and not draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head   <= '0;
      r_skid   <= '0;
      r_head_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (!r_head_v) begin
            r_head   <= mem_rd_data;
            r_head_v <= 1'b1;
          end else begin
            r_skid   <= mem_rd_data;
            r_skid_v <= 1'b1;
          end
        end
        2'b01: begin
          if (r_skid_v) begin
            r_head   <= r_skid;
            r_skid_v <= 1'b0;
          end else begin
            r_head_v <= 1'b0;
          end
        end
        2'b11: begin
          if (r_skid_v) begin
            r_head <= r_skid;
            r_skid <= mem_rd_data;
          end else begin
            r_head <= mem_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_mem_read.sv
// Scoreboard bench for ctrl_mem_read: stimulus pushes expected words, a
// negedge monitor pops and compares every handshake.
module tb_ctrl_mem_read;
  localparam int AW = 3;
  localparam int MS = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start, m_ready;
  logic [AW-1:0] start_addr, mem_addr;
  logic [AW:0]   rd_len;
  logic          mem_rd_en, m_valid, m_last, busy, done;
  logic [DW-1:0] mem_rd_data, m_data;

  ctrl_mem_read #(.MEM_ADDR_WIDTH(AW), .MEM_SIZE(MS), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .rd_len(rd_len), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [MS];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  typedef struct {logic [DW-1:0] d; logic l;} exp_t;
  exp_t sbq[$];
  exp_t e;

  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0;
  int hs_cnt = 0, rden_cnt = 0, done_cnt = 0, first_hs = 0, last_hs = 0, done_cyc = 0, outs = 0;
  int addr_log[$];
  logic hold = 1'b0;
  logic [DW-1:0] hold_d;
  int rdy_mode = 0, pidx = 0;
  int pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};
  int exp_a[4] = '{6, 7, 0, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) m_ready = 1'b1;
    else begin
      m_ready = pat[pidx][0];
      pidx = (pidx + 1) % 8;
    end
  end

  always @(posedge clk)
    if (!reset && start) assert (rd_len <= MS) else $error("rd_len %0d exceeds MEM_SIZE", rd_len);

  always @(negedge clk) begin
    if (reset) begin
      outs = 0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", {31'b0, m_valid}, 1);
        chk("hold_data", {16'b0, m_data}, {16'b0, hold_d});
      end
      if (!m_valid) chk("last_without_valid", {31'b0, m_last}, 0);
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0d with empty scoreboard", m_data);
        end else begin
          e = sbq.pop_front();
          chk("data", {16'b0, m_data}, {16'b0, e.d});
          chk("last", {31'b0, m_last}, {31'b0, e.l});
        end
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end
      if (mem_rd_en) begin
        rden_cnt++;
        addr_log.push_back(int'(mem_addr));
      end
      outs = outs + int'(mem_rd_en) - int'(m_valid && m_ready);
      if (mem_rd_en) chk("outstanding_le2", {31'b0, outs <= 2}, 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hold = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  task automatic clr();
    hs_cnt = 0; rden_cnt = 0; done_cnt = 0; first_hs = 0; last_hs = 0;
    addr_log.delete();
  endtask

  task automatic do_start(input int a, input int l, input bit push);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = AW'(a);
    rd_len = (AW+1)'(l);
    if (push)
      for (int i = 0; i < l; i++) sbq.push_back('{d: DW'((a + i) % MS + 10), l: (i == l - 1)});
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt == 0 && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_seen", {31'b0, done_cnt != 0}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MS; i++) mem[i] = DW'(i + 10);
    reset = 1'b1; start = 1'b1; start_addr = 3'd3; rd_len = 4'd5; m_ready = 1'b1;

    // reset held with start asserted
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", {24'b0, m_valid, m_last, busy, done, mem_rd_en, mem_addr},
          32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {30'b0, busy, mem_rd_en}, 0);

    // full block, continuous ready
    clr(); rdy_mode = 0;
    do_start(0, 8, 1);
    wait_done(40);
    chk("full_rden", rden_cnt, 8);
    chk("full_hs", hs_cnt, 8);
    chk("full_consecutive", last_hs - first_hs, 7);
    chk("full_done_time", done_cyc, last_hs + 1);
    chk("full_done_once", done_cnt, 1);
    chk("full_sb_empty", sbq.size(), 0);
    @(negedge clk);
    chk("full_idle_after", {30'b0, busy, done}, 0);

    // address wrap
    clr();
    do_start(6, 4, 1);
    wait_done(40);
    chk("wrap_rden", addr_log.size(), 4);
    if (addr_log.size() == 4)
      for (int i = 0; i < 4; i++) chk("wrap_addr", addr_log[i], exp_a[i]);
    chk("wrap_sb_empty", sbq.size(), 0);

    // backpressure
    clr(); rdy_mode = 1;
    do_start(0, 8, 1);
    wait_done(120);
    chk("bp_hs", hs_cnt, 8);
    chk("bp_rden", rden_cnt, 8);
    chk("bp_sb_empty", sbq.size(), 0);

    // start while busy is ignored
    clr();
    do_start(0, 8, 1);
    repeat (3) @(posedge clk);
    do_start(5, 3, 0);
    wait_done(120);
    chk("busy_start_hs", hs_cnt, 8);
    chk("busy_start_rden", rden_cnt, 8);
    chk("busy_start_sb_empty", sbq.size(), 0);

    // zero length
    clr(); rdy_mode = 0;
    do_start(0, 0, 1);
    wait_done(10);
    chk("zero_done_time", done_cyc, acc_cyc);
    chk("zero_rden", rden_cnt, 0);
    chk("zero_hs", hs_cnt, 0);

    // reset mid-stream
    clr();
    do_start(0, 8, 1);
    for (int n = 0; n < 40 && hs_cnt < 3; n++) begin
      @(negedge clk); #1;
    end
    chk("mid_hs_reached", {31'b0, hs_cnt >= 3}, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    chk("mid_reset_valid", {30'b0, m_valid, busy}, 0);
    repeat (3) @(negedge clk);
    chk("mid_reset_no_done", done_cnt, 0);
    clr();
    do_start(0, 2, 1);
    wait_done(40);
    chk("post_reset_hs", hs_cnt, 2);
    chk("post_reset_sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
